// File: rtl/aes_mix_pkg.sv
// Shared types, constants and GF(2^8) helpers for the sequential MixColumns block.
package aes_mix_pkg;

   localparam int NCOL = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } fsm_e;

   // Entry k is the coefficient applied to byte (r+k) mod 4 of the column.
   localparam logic [3:0][3:0] MC_FWD = {4'h1, 4'h1, 4'h3, 4'h2};
   localparam logic [3:0][3:0] MC_INV = {4'h9, 4'hd, 4'hb, 4'he};

   function automatic logic [7:0] xt2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) p = p ^ x;
         x = xt2(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] mix(input logic [31:0] col, input logic [3:0][3:0] cf);
      logic [31:0] o;
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            o[8*r +: 8] = o[8*r +: 8] ^ gmul(col[8*((r+k)%4) +: 8], cf[k]);
      return o;
   endfunction

endpackage

// File: rtl/aes_mixcolumn_word.sv
// Combinational single-column MixColumns; inverse path only with AES_MIXCOL_DEC_EN.
module aes_mixcolumn_word
   import aes_mix_pkg::*;
(
   input  logic [31:0] col_i,
   input  logic        dec_i,
   output logic [31:0] col_o
);

`ifdef AES_MIXCOL_DEC_EN
   assign col_o = dec_i ? mix(col_i, MC_INV) : mix(col_i, MC_FWD);
`else
   logic unused_dec;
   assign unused_dec = dec_i;
   assign col_o      = mix(col_i, MC_FWD);
`endif

endmodule

// File: rtl/aes_mixcolumn_seq.sv
// Sequential MixColumns/InvMixColumns over a 128-bit state, LANES columns per cycle.
// Inverse mode is built only when AES_MIXCOL_DEC_EN is defined.
module aes_mixcolumn_seq
   import aes_mix_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic         g_clk,
   input  logic         g_resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_dec,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("aes_mixcolumn_seq: LANES must be 1, 2 or 4");
   end

   localparam int NSTEP = NCOL / LANES;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   fsm_e                       fsm_q;
   logic [CW-1:0]              cnt_q;
   logic                       dec_q;
   logic                       vld_q;
   logic [NCOL-1:0][31:0]      st_q, st_d;
   logic [LANES-1:0][31:0]     lane_in, lane_out;
   logic [1:0]                 base;
   logic                       dec_in;

`ifdef AES_MIXCOL_DEC_EN
   assign dec_in = in_dec;
`else
   logic unused_in_dec;
   assign unused_in_dec = in_dec;
   assign dec_in        = 1'b0;
`endif

   // Two-bit column index wraps naturally, so no lane can address past column 3.
   assign base = 2'(int'(cnt_q) * LANES);

   always_comb begin
      lane_in = '0;
      for (int l = 0; l < LANES; l++)
         lane_in[l] = st_q[base + 2'(l)];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      aes_mixcolumn_word u_word (
         .col_i (lane_in[l]),
         .dec_i (dec_q),
         .col_o (lane_out[l])
      );
   end

   always_comb begin
      st_d = st_q;
      for (int l = 0; l < LANES; l++)
         st_d[base + 2'(l)] = lane_out[l];
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         fsm_q <= S_IDLE;
         cnt_q <= '0;
         dec_q <= 1'b0;
         vld_q <= 1'b0;
         st_q  <= '0;
      end else begin
         case (fsm_q)
            S_IDLE: if (in_valid) begin
               st_q  <= in_state;
               dec_q <= dec_in;
               cnt_q <= '0;
               fsm_q <= S_BUSY;
            end
            S_BUSY: begin
               st_q <= st_d;
               if (cnt_q == CW'(NSTEP - 1)) begin
                  cnt_q <= '0;
                  vld_q <= 1'b1;
                  fsm_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DONE: if (out_ready) begin
               vld_q <= 1'b0;
               if (in_valid) begin
                  st_q  <= in_state;
                  dec_q <= dec_in;
                  cnt_q <= '0;
                  fsm_q <= S_BUSY;
               end else begin
                  fsm_q <= S_IDLE;
               end
            end
            default: fsm_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && out_ready);
   assign out_valid = vld_q;
   assign out_state = st_q;
   assign busy      = (fsm_q != S_IDLE);

endmodule

// File: tb/tb_aes_mixcolumn_seq.sv
// Bench for aes_mixcolumn_seq: LANES=1/2/4 instances vs. a GF(2^8) matrix reference model.
module tb_aes_mixcolumn_seq;

   logic               g_clk = 1'b0;
   logic               g_resetn = 1'b0;
   logic [2:0]         in_valid, in_ready, in_dec, out_valid, out_ready, busy;
   logic [2:0][127:0]  in_state, out_state;

   int n_tot = 0;
   int n_bad = 0;

   always #5 g_clk = ~g_clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      aes_mixcolumn_seq #(.LANES(k == 0 ? 1 : (k == 1 ? 2 : 4))) u_dut (
         .g_clk     (g_clk),
         .g_resetn  (g_resetn),
         .in_valid  (in_valid[k]),
         .in_ready  (in_ready[k]),
         .in_dec    (in_dec[k]),
         .in_state  (in_state[k]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .out_state (out_state[k]),
         .busy      (busy[k])
      );
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Full 8x8 shift-and-add product reduced by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      int p, x;
      p = 0;
      x = int'(a);
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x << 1;
         if (x & 32'h100) x = x ^ 32'h11b;
      end
      return 8'(p);
   endfunction

   function automatic logic [127:0] ref_mix(input logic [127:0] st, input logic dec);
      logic [7:0] m [4];
      logic [7:0] b [4];
      logic [127:0] o;
      logic d;
`ifdef AES_MIXCOL_DEC_EN
      d = dec;
`else
      d = 1'b0;
`endif
      if (d) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
      else   begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) b[r] = st[32*c + 8*r +: 8];
         for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
               o[32*c + 8*r +: 8] = o[32*c + 8*r +: 8] ^ gf_mul(b[(r+k)%4], m[k]);
      end
      return o;
   endfunction

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   // One transfer from IDLE; returns the result and edges from transfer to out_valid.
   task automatic run_op(input int k, input logic [127:0] st, input logic dec, input int stall,
                         output logic [127:0] res, output int lat);
      in_state[k] = st;
      in_dec[k]   = dec;
      in_valid[k] = 1'b1;
      #1;
      chk($sformatf("rdy_idle%0d", k), 128'(in_ready[k]), 128'(1));
      tick();
      in_valid[k] = 1'b0;
      in_state[k] = '1;
      lat = 1;
      while (!out_valid[k] && lat < 20) begin
         tick();
         lat++;
      end
      res = out_state[k];
      repeat (stall) tick();
      if (stall > 0) chk($sformatf("stall_hold%0d", k), out_state[k], res);
      out_ready[k] = 1'b1;
      tick();
      out_ready[k] = 1'b0;
      chk($sformatf("idle_after%0d", k), {126'd0, busy[k], out_valid[k]}, 128'd0);
   endtask

   initial begin
      logic [127:0] res, st, exp, r2;
      int lat;
      int exp_lat [3];
      exp_lat[0] = 5; exp_lat[1] = 3; exp_lat[2] = 2;
      in_valid = '0; in_dec = '0; out_ready = '0; in_state = '0;

      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_ov%0d", k), 128'(out_valid[k]), 128'd0);
         chk($sformatf("rst_os%0d", k), out_state[k], 128'd0);
         chk($sformatf("rst_ir%0d", k), 128'(in_ready[k]), 128'd1);
         chk($sformatf("rst_bz%0d", k), 128'(busy[k]), 128'd0);
      end
      g_resetn = 1'b1;
      tick();

      for (int k = 0; k < 3; k++) begin
         run_op(k, {96'd0, 32'h455313db}, 1'b0, 0, res, lat);
         chk($sformatf("fips_fwd%0d", k), res, {96'd0, 32'hbca14d8e});
         chk($sformatf("lat_fwd%0d", k), 128'(lat), 128'(exp_lat[k]));

         run_op(k, {4{32'hbca14d8e}}, 1'b1, 1, res, lat);
`ifdef AES_MIXCOL_DEC_EN
         exp = {4{32'h455313db}};
`else
         exp = ref_mix({4{32'hbca14d8e}}, 1'b0);
`endif
         chk($sformatf("inv_all%0d", k), res, exp);
         chk($sformatf("lat_inv%0d", k), 128'(lat), 128'(exp_lat[k]));

         run_op(k, {32'h455313db, 32'h5c220af2, 32'hc6c6c6c6, 32'h01010101}, 1'b0, 0, res, lat);
         chk($sformatf("mixed%0d", k), res,
             {32'hbca14d8e, 32'h9d58dc9f, 32'hc6c6c6c6, 32'h01010101});

         run_op(k, {96'd0, 32'h455313db}, 1'b1, 0, res, lat);
`ifdef AES_MIXCOL_DEC_EN
         exp = ref_mix({96'd0, 32'h455313db}, 1'b1);
`else
         exp = {96'd0, 32'hbca14d8e};
`endif
         chk($sformatf("dec1%0d", k), res, exp);
      end

      // Backpressure then back-to-back accept on LANES=1.
      st = {$urandom, $urandom, $urandom, $urandom};
      in_state[0] = st; in_dec[0] = 1'b0; in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      while (!out_valid[0] && lat < 40) begin tick(); lat++; end
      res = out_state[0];
      chk("bp_res", res, ref_mix(st, 1'b0));
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid", {out_valid[0], in_ready[0]}, 128'b10);
         chk("bp_state", out_state[0], res);
      end
      r2 = {$urandom, $urandom, $urandom, $urandom};
      in_state[0] = r2; in_dec[0] = 1'b1; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      #1;
      chk("b2b_ready", 128'(in_ready[0]), 128'd1);
      tick();
      in_valid[0] = 1'b0; out_ready[0] = 1'b0;
      chk("b2b_busy", {busy[0], out_valid[0]}, 128'b10);
      lat = 1;
      while (!out_valid[0] && lat < 20) begin tick(); lat++; end
      chk("b2b_lat", 128'(lat), 128'd5);
      chk("b2b_res", out_state[0], ref_mix(r2, 1'b1));
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;

      // Reset while LANES=2 instance is BUSY.
      in_state[1] = {4{32'h455313db}}; in_valid[1] = 1'b1;
      tick();
      in_valid[1] = 1'b0;
      chk("mid_busy", 128'(busy[1]), 128'd1);
      g_resetn = 1'b0;
      tick();
      chk("mid_rst", {out_valid[1], in_ready[1], busy[1]}, 128'b010);
      chk("mid_rst_st", out_state[1], 128'd0);
      g_resetn = 1'b1;
      repeat (5) tick();
      chk("mid_no_out", {out_valid[1], busy[1]}, 128'b00);

      for (int n = 0; n < 15; n++) begin
         for (int k = 0; k < 3; k++) begin
            logic d;
            st = {$urandom, $urandom, $urandom, $urandom};
            d  = 1'($urandom_range(0, 1));
            run_op(k, st, d, $urandom_range(0, 3), res, lat);
            chk($sformatf("rnd%0d_%0d", k, n), res, ref_mix(st, d));
         end
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
